// File: rtl/ddr_port_arbiter_pkg.sv
// ddr_port_arbiter_pkg: shared widths and FSM state encoding for the DDR port arbiter
package ddr_port_arbiter_pkg;
    localparam int BL_W   = 6;
    localparam int ADDR_W = 30;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WFILL  = 3'd1,
        WCMD   = 3'd2,
        RCMD   = 3'd3,
        RDRAIN = 3'd4,
        DONE   = 3'd5
    } state_t;
endpackage

// File: rtl/ddr_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin pick with a registered last-grant flag
// ports: clk, reset_n | req[1:0] requests, take commits the pick | pick (comb), last (registered, 1 after reset)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       pick,
    output logic       last
);
    // the requester not granted last time wins whenever it is asking
    assign pick = req[~last] ? ~last : last;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last <= 1'b1;
        else if (take && |req) last <= pick;
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one MIG port (c3_p0) between two burst requesters m0/m1
// ports: clk, reset_n | mN_req/rw/addr/bl/wdata/wmask in, mN_wnext/rdata/rvalid/done/err out
//        c3_p0 cmd/wr/rd MIG port | busy (state != IDLE), grant (current or last granted index)
module ddr_port_arbiter
    import ddr_port_arbiter_pkg::*;
#(
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [BL_W-1:0]   m0_bl,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic              m0_wnext,
    output logic [31:0]       m0_rdata,
    output logic              m0_rvalid,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [BL_W-1:0]   m1_bl,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic              m1_wnext,
    output logic [31:0]       m1_rdata,
    output logic              m1_rvalid,
    output logic              m1_done,
    output logic              m1_err,
    output logic              c3_p0_cmd_en,
    output logic              c3_p0_cmd_rw,
    output logic [BL_W-1:0]   c3_p0_cmd_bl,
    output logic [ADDR_W-1:0] c3_p0_cmd_byte_addr,
    input  logic              c3_p0_cmd_full,
    output logic              c3_p0_wr_en,
    output logic [3:0]        c3_p0_wr_mask,
    output logic [31:0]       c3_p0_wr_data,
    input  logic              c3_p0_wr_full,
    output logic              c3_p0_rd_en,
    input  logic [31:0]       c3_p0_rd_data,
    input  logic              c3_p0_rd_empty,
    output logic              busy,
    output logic              grant
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    state_t            state;
    logic              pick, err_f, sel_rw, done;
    logic [BL_W-1:0]   cnt, sel_bl;
    logic [ADDR_W-1:0] sel_addr;
    logic [TW-1:0]     tmo;
    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({m1_req, m0_req}),
        .take    (state == IDLE),
        .pick    (pick),
        .last    (grant)
    );
    assign sel_rw        = pick ? m1_rw : m0_rw;
    assign sel_bl        = pick ? m1_bl : m0_bl;
    assign sel_addr      = pick ? m1_addr : m0_addr;
    assign busy          = state != IDLE;
    assign done          = state == DONE;
    assign c3_p0_wr_en   = state == WFILL && !c3_p0_wr_full;
    assign c3_p0_rd_en   = state == RDRAIN && !c3_p0_rd_empty;
    // the write bus idles at zero outside WFILL
    assign c3_p0_wr_data = state == WFILL ? (grant ? m1_wdata : m0_wdata) : '0;
    assign c3_p0_wr_mask = state == WFILL ? (grant ? m1_wmask : m0_wmask) : '0;
    assign m0_rdata      = c3_p0_rd_data;
    assign m1_rdata      = c3_p0_rd_data;
    assign m0_wnext      = c3_p0_wr_en && !grant;
    assign m1_wnext      = c3_p0_wr_en && grant;
    assign m0_rvalid     = c3_p0_rd_en && !grant;
    assign m1_rvalid     = c3_p0_rd_en && grant;
    assign m0_done       = done && !grant;
    assign m1_done       = done && grant;
    assign m0_err        = m0_done && err_f;
    assign m1_err        = m1_done && err_f;
    // the cmd_* registers double as the latched transaction fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            c3_p0_cmd_en        <= 1'b0;
            c3_p0_cmd_rw        <= 1'b1;
            c3_p0_cmd_bl        <= '0;
            c3_p0_cmd_byte_addr <= '0;
            cnt                 <= '0;
            tmo                 <= '0;
            err_f               <= 1'b0;
        end else begin
            c3_p0_cmd_en <= 1'b0;
            case (state)
                IDLE: if (m0_req || m1_req) begin
                    c3_p0_cmd_rw        <= sel_rw;
                    c3_p0_cmd_bl        <= sel_bl;
                    c3_p0_cmd_byte_addr <= sel_addr;
                    cnt                 <= sel_bl;
                    tmo                 <= '0;
                    err_f               <= 1'b0;
                    state               <= sel_rw ? RCMD : WFILL;
                end
                WFILL: if (!c3_p0_wr_full) begin
                    if (cnt == '0) state <= WCMD;
                    else cnt <= cnt - 1'b1;
                end
                WCMD, RCMD: if (!c3_p0_cmd_full) begin
                    c3_p0_cmd_en <= 1'b1;
                    state        <= state == WCMD ? DONE : RDRAIN;
                end
                RDRAIN: if (!c3_p0_rd_empty) begin
                    tmo <= '0;
                    if (cnt == '0) state <= DONE;
                    else cnt <= cnt - 1'b1;
                end else if (tmo == TW'(RD_TIMEOUT - 1)) begin
                    err_f <= 1'b1;
                    state <= DONE;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: randomized two-master bench with a behavioural MIG model and per-transaction scoreboard
module tb_ddr_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req = 2'b00, rw = 2'b00;
    logic [29:0] ad [2];
    logic [5:0]  bl [2];
    logic [31:0] wdat [2];
    logic [3:0]  wmsk [2];
    logic [1:0]  wnext, rvalid, done, err;
    logic [31:0] rdata [2];
    logic        c3_p0_cmd_en, c3_p0_cmd_rw, c3_p0_wr_en, c3_p0_rd_en, busy, grant;
    logic [5:0]  c3_p0_cmd_bl;
    logic [29:0] c3_p0_cmd_byte_addr;
    logic [3:0]  c3_p0_wr_mask;
    logic [31:0] c3_p0_wr_data;
    logic        c3_p0_cmd_full = 1'b0, c3_p0_wr_full = 1'b0, c3_p0_rd_empty = 1'b1;
    logic [31:0] c3_p0_rd_data = 32'h0;
    int n_chk = 0, n_pass = 0, cyc = 0, rd_at = 0, wf_mode = 0, cf_hold = 0, last_cf = 0, lastg = 1, ndone = 0;
    bit stall_en = 1'b0, cf_rand = 1'b0, rd_kill = 1'b0, stall = 1'b0, rd_pop = 1'b0;
    int wrn [2] = '{0, 0};
    int cmdn [2] = '{0, 0};
    int wr_at_cmd [2] = '{0, 0};
    int ccyc [2] = '{0, 0};
    logic        crw [2];
    logic [5:0]  cbl [2];
    logic [29:0] cad [2];
    logic [31:0] rq [$];
    logic [31:0] exp_rd [$];
    int done_q [$];
    logic [31:0] wsrc [2][64];
    logic [3:0]  ksrc [2][64];

    ddr_port_arbiter #(.RD_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(req[0]), .m0_rw(rw[0]), .m0_addr(ad[0]), .m0_bl(bl[0]), .m0_wdata(wdat[0]), .m0_wmask(wmsk[0]),
        .m0_wnext(wnext[0]), .m0_rdata(rdata[0]), .m0_rvalid(rvalid[0]), .m0_done(done[0]), .m0_err(err[0]),
        .m1_req(req[1]), .m1_rw(rw[1]), .m1_addr(ad[1]), .m1_bl(bl[1]), .m1_wdata(wdat[1]), .m1_wmask(wmsk[1]),
        .m1_wnext(wnext[1]), .m1_rdata(rdata[1]), .m1_rvalid(rvalid[1]), .m1_done(done[1]), .m1_err(err[1]),
        .c3_p0_cmd_en(c3_p0_cmd_en), .c3_p0_cmd_rw(c3_p0_cmd_rw), .c3_p0_cmd_bl(c3_p0_cmd_bl),
        .c3_p0_cmd_byte_addr(c3_p0_cmd_byte_addr), .c3_p0_cmd_full(c3_p0_cmd_full),
        .c3_p0_wr_en(c3_p0_wr_en), .c3_p0_wr_mask(c3_p0_wr_mask), .c3_p0_wr_data(c3_p0_wr_data),
        .c3_p0_wr_full(c3_p0_wr_full), .c3_p0_rd_en(c3_p0_rd_en), .c3_p0_rd_data(c3_p0_rd_data),
        .c3_p0_rd_empty(c3_p0_rd_empty), .busy(busy), .grant(grant)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", t, got, exp);
    endtask

    // MIG model: FIFO flags and read data change just after each rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rd_pop && rq.size() != 0) void'(rq.pop_front());
        stall = stall_en && !stall && $urandom_range(0, 3) == 0;
        c3_p0_rd_empty = rd_kill || rq.size() == 0 || cyc < rd_at || stall;
        c3_p0_rd_data = rq.size() != 0 ? rq[0] : 32'h0;
        c3_p0_wr_full = wf_mode == 2 ? !c3_p0_wr_full : wf_mode == 1 && $urandom_range(0, 2) == 0;
        c3_p0_cmd_full = cf_hold > 0 || (cf_rand && $urandom_range(0, 3) == 0);
        if (cf_hold > 0) cf_hold--;
        if (c3_p0_cmd_full) last_cf = cyc;
    end

    // MIG-side monitor: attributes pushes and commands to the granted master
    initial begin : mon
        logic [31:0] w;
        forever begin
            @(negedge clk);
            rd_pop = c3_p0_rd_en;
            if (reset_n) begin
                if (c3_p0_wr_en) begin
                    chk("wr_en_while_full", 32'(c3_p0_wr_full), 0);
                    wrn[grant]++;
                end
                if (c3_p0_cmd_en) begin
                    cmdn[grant]++;
                    crw[grant] = c3_p0_cmd_rw;
                    cbl[grant] = c3_p0_cmd_bl;
                    cad[grant] = c3_p0_cmd_byte_addr;
                    wr_at_cmd[grant] = wrn[grant];
                    ccyc[grant] = cyc;
                    if (c3_p0_cmd_rw) begin
                        for (int i = 0; i <= int'(c3_p0_cmd_bl); i++) begin
                            w = $urandom;
                            rq.push_back(w);
                            exp_rd.push_back(w);
                        end
                        rd_at = cyc + 5;
                    end
                end
                if (|done) begin
                    chk("done_onehot", 32'(&done), 0);
                    ndone++;
                end
                if (|err) chk("err_without_done", 32'(err & ~done), 0);
            end
        end
    end

    task automatic do_txn(input int m, input bit r, input logic [29:0] a, input logic [5:0] b, input bit xe);
        int nw, nr, idx, wb, cb, dcyc;
        bit adv, got, e;
        for (int i = 0; i < 64; i++) begin
            wsrc[m][i] = $urandom;
            ksrc[m][i] = 4'($urandom);
        end
        @(posedge clk);
        #1;
        wb = wrn[m];
        cb = cmdn[m];
        rw[m] = r; ad[m] = a; bl[m] = b; wdat[m] = wsrc[m][0]; wmsk[m] = ksrc[m][0]; req[m] = 1'b1;
        nw = 0; nr = 0; idx = 0; got = 1'b0; e = 1'b0; dcyc = 0;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge clk);
            adv = wnext[m];
            if (adv) begin
                chk("wdata", c3_p0_wr_data, wsrc[m][idx]);
                chk("wmask", 32'(c3_p0_wr_mask), 32'(ksrc[m][idx]));
                nw++;
            end
            if (rvalid[m]) begin
                if (exp_rd.size() == 0) chk("rvalid_extra", 1, 0);
                else chk("rdata", rdata[m], exp_rd.pop_front());
                nr++;
            end
            if (done[m]) begin
                got = 1'b1;
                e = err[m];
                dcyc = cyc;
                done_q.push_back(m);
                chk("grant_at_done", 32'(grant), m);
            end else begin
                @(posedge clk);
                #1;
                if (adv && idx < 63) begin
                    idx++;
                    wdat[m] = wsrc[m][idx];
                    wmsk[m] = ksrc[m][idx];
                end
            end
        end
        chk("done_seen", 32'(got), 1);
        @(posedge clk);
        #1;
        req[m] = 1'b0;
        @(negedge clk);
        chk("idle_after_done", 32'(busy), 0);
        chk("err", 32'(e), 32'(xe));
        chk("cmd_count", cmdn[m] - cb, 1);
        chk("cmd_rw", 32'(crw[m]), 32'(r));
        chk("cmd_bl", 32'(cbl[m]), 32'(b));
        chk("cmd_addr", 32'(cad[m]), 32'(a));
        chk("wnext_count", nw, r ? 0 : int'(b) + 1);
        chk("wr_en_count", wrn[m] - wb, r ? 0 : int'(b) + 1);
        if (!r) chk("data_before_cmd", wr_at_cmd[m] - wb, int'(b) + 1);
        if (r) chk("rvalid_count", nr, xe ? 0 : int'(b) + 1);
        if (xe) chk("timeout_latency", dcyc - ccyc[m], 15);
        lastg = m;
    endtask

    task automatic pair(input bit r0, input logic [29:0] a0, input logic [5:0] b0,
                        input bit r1, input logic [29:0] a1, input logic [5:0] b1);
        int first;
        first = lastg == 1 ? 0 : 1;
        done_q.delete();
        fork
            do_txn(0, r0, a0, b0, 1'b0);
            do_txn(1, r1, a1, b1, 1'b0);
        join
        chk("rr_first", done_q.size() > 0 ? done_q[0] : -1, first);
        chk("rr_second", done_q.size() > 1 ? done_q[1] : -1, 1 - first);
    endtask

    task automatic rst_chk();
        chk("rst_strobes", 32'({c3_p0_cmd_en, c3_p0_wr_en, c3_p0_rd_en, busy, wnext, rvalid, done, err}), 0);
        chk("rst_grant", 32'(grant), 1);
        chk("rst_cmd_rw", 32'(c3_p0_cmd_rw), 1);
        chk("rst_cmd_bl", 32'(c3_p0_cmd_bl), 0);
        chk("rst_cmd_addr", 32'(c3_p0_cmd_byte_addr), 0);
        chk("rst_wr_mask", 32'(c3_p0_wr_mask), 0);
        chk("rst_wr_data", c3_p0_wr_data, 0);
    endtask

    function automatic logic [5:0] rbl();
        int k;
        k = $urandom_range(0, 5);
        return k == 0 ? 6'd0 : k == 1 ? 6'd63 : 6'($urandom_range(0, 15));
    endfunction

    initial begin
        int m, n, nd;
        for (int i = 0; i < 2; i++) begin
            ad[i] = '0; bl[i] = '0; wdat[i] = '0; wmsk[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_chk();
        reset_n = 1'b1;
        pair(1'b0, 30'h100, 6'd3, 1'b1, 30'h2000, 6'd1);
        repeat (4) begin
            wf_mode = $urandom_range(0, 2);
            stall_en = 1'b1;
            cf_rand = 1'b1;
            pair(1'($urandom), 30'($urandom), rbl(), 1'($urandom), 30'($urandom), rbl());
        end
        wf_mode = 2; cf_rand = 1'b0; stall_en = 1'b0;
        do_txn(1, 1'b0, 30'h300, 6'd63, 1'b0);
        wf_mode = 0;
        cf_hold = 10;
        do_txn(0, 1'b0, 30'h400, 6'd1, 1'b0);
        chk("cmd_held_off", 32'(ccyc[0] > last_cf), 1);
        rd_kill = 1'b1;
        do_txn(1, 1'b1, 30'h500, 6'd7, 1'b1);
        rd_kill = 1'b0;
        rq.delete();
        exp_rd.delete();
        @(posedge clk);
        #1;
        rw[0] = 1'b0; ad[0] = 30'h2400; bl[0] = 6'd20; wdat[0] = $urandom | 32'h1; wmsk[0] = 4'ha; req[0] = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            @(negedge clk);
            if (wnext[0]) n++;
        end
        chk("rst_mid_reach_wfill", n, 3);
        nd = ndone;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        rst_chk();
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        reset_n = 1'b1;
        lastg = 1;
        @(negedge clk);
        chk("rst_no_done", ndone, nd);
        pair(1'b1, 30'h600, 6'd2, 1'b0, 30'h700, 6'd5);
        repeat (16) begin
            m = $urandom_range(0, 1);
            wf_mode = $urandom_range(0, 2);
            stall_en = 1'($urandom);
            cf_rand = 1'($urandom);
            do_txn(m, 1'($urandom), 30'($urandom), rbl(), 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
